// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo -- UART transmitter with a built-in transmit FIFO.
//
// The CPU pushes characters into the FIFO. The serialiser pops them and sends
// them back-to-back on tx. Frame format: start bit, DATA_BITS data bits LSB
// first, an optional parity bit, then STOP_BITS stop bits. Every bit lasts
// CLKS_PER_BIT clocks.
//
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset (aborts any frame in flight)
//   wr_en     push request, sampled on the rising clk edge
//   wr_data   character to push
//   ovf_clr   clears the sticky overflow flag
//   tx        serial line, idle high, driven from a flop
//   full      FIFO holds DEPTH entries (registered)
//   empty     FIFO holds no entries (registered)
//   level     current FIFO occupancy, 0..DEPTH
//   overflow  sticky: a push was dropped because the FIFO was full
//   busy      serialiser active or FIFO not empty
module uart_tx_fifo #(
  parameter int DATA_BITS    = 8,
  parameter int DEPTH        = 16,
  parameter int CLKS_PER_BIT = 5200,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_BITS-1:0]     wr_data,
  input  logic                     ovf_clr,
  output logic                     tx,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);

  // ---------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_reg;
  logic [PTR_W-1:0]     rd_ptr_reg;
  logic [LVL_W-1:0]     level_reg;
  logic [LVL_W-1:0]     level_next;
  logic                 full_reg;
  logic                 empty_reg;
  logic                 ovf_reg;
  logic                 push;
  logic                 pop;

  // The push is gated by the registered full flag. A pop in the same cycle
  // does not make room for that push.
  assign push = wr_en && !full_reg;

  // Storage array: no reset, write-only port here. The read happens in the
  // data latch below.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_comb begin
    level_next = level_reg;
    case ({push, pop})
      2'b10:   level_next = level_reg + LVL_W'(1);
      2'b01:   level_next = level_reg - LVL_W'(1);
      default: level_next = level_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
      ovf_reg    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      level_reg <= level_next;
      full_reg  <= (level_next == LVL_FULL);
      empty_reg <= (level_next == '0);
      // A dropped push takes priority over a simultaneous clear.
      if (wr_en && full_reg) begin
        ovf_reg <= 1'b1;
      end else if (ovf_clr) begin
        ovf_reg <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Serialiser
  // ---------------------------------------------------------------------
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t               state_reg;
  state_t               state_next;
  logic [CNT_W-1:0]     cnt_reg;
  logic [CNT_W-1:0]     cnt_next;
  logic [BIT_W-1:0]     bit_reg;
  logic [BIT_W-1:0]     bit_next;
  logic [DATA_BITS-1:0] data_reg;
  logic                 tx_reg;
  logic                 tx_next;
  logic                 par_bit;
  logic                 cnt_done;

  // The character is captured on the pop edge. This is the registered read
  // of the storage array. The first data bit is needed only after a whole
  // start bit, so the capture is never late.
  always_ff @(posedge clk) begin
    if (pop) begin
      data_reg <= mem[rd_ptr_reg];
    end
  end

  assign cnt_done = (cnt_reg == CNT_LAST);
  assign par_bit  = (PARITY == 1) ? ~(^data_reg) : (^data_reg);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    pop        = 1'b0;
    tx_next    = 1'b1;

    if (state_reg != ST_IDLE) begin
      cnt_next = cnt_done ? '0 : cnt_reg + CNT_W'(1);
    end

    case (state_reg)
      ST_IDLE: begin
        if (!empty_reg) begin
          pop        = 1'b1;
          state_next = ST_START;
          cnt_next   = '0;
        end
      end
      ST_START: begin
        if (cnt_done) begin
          state_next = ST_DATA;
          bit_next   = '0;
        end
      end
      ST_DATA: begin
        if (cnt_done) begin
          if (bit_reg == DATA_LAST) begin
            bit_next   = '0;
            state_next = (PARITY != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_next = bit_reg + BIT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (cnt_done) begin
          state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        // bit_reg counts the stop bits. If the FIFO still has data, the last
        // stop cycle pops the next character, so there is no idle gap.
        if (cnt_done) begin
          if (bit_reg == STOP_LAST) begin
            bit_next = '0;
            if (!empty_reg) begin
              pop        = 1'b1;
              state_next = ST_START;
            end else begin
              state_next = ST_IDLE;
            end
          end else begin
            bit_next = bit_reg + BIT_W'(1);
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // tx is registered. Its value follows the state being entered.
    case (state_next)
      ST_START:  tx_next = 1'b0;
      ST_DATA:   tx_next = data_reg[bit_next];
      ST_PARITY: tx_next = par_bit;
      default:   tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      tx_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      tx_reg    <= tx_next;
    end
  end

  assign tx       = tx_reg;
  assign full     = full_reg;
  assign empty    = empty_reg;
  assign level    = level_reg;
  assign overflow = ovf_reg;
  assign busy     = (state_reg != ST_IDLE) || !empty_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed testbench for uart_tx_fifo. It uses four instances at
// CLKS_PER_BIT=4 and DEPTH=16:
//   0: 8N1   1: 7E1   2: 7O1   3: 8N2
// Expected frames are written as strings in transmit order (start first).
module tb_uart_tx_fifo;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       ovf_clr;
  logic       wr_en    [4];
  logic [7:0] wr_data  [4];
  logic       tx       [4];
  logic       full     [4];
  logic       empty    [4];
  logic       overflow [4];
  logic       busy     [4];
  logic [4:0] level    [4];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DATA_BITS(8), .DEPTH(16), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .wr_en(wr_en[0]), .wr_data(wr_data[0]), .ovf_clr(ovf_clr),
    .tx(tx[0]), .full(full[0]), .empty(empty[0]), .level(level[0]),
    .overflow(overflow[0]), .busy(busy[0]));

  uart_tx_fifo #(.DATA_BITS(7), .DEPTH(16), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1)) u_7e1 (
    .clk(clk), .rst(rst), .wr_en(wr_en[1]), .wr_data(wr_data[1][6:0]), .ovf_clr(ovf_clr),
    .tx(tx[1]), .full(full[1]), .empty(empty[1]), .level(level[1]),
    .overflow(overflow[1]), .busy(busy[1]));

  uart_tx_fifo #(.DATA_BITS(7), .DEPTH(16), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1)) u_7o1 (
    .clk(clk), .rst(rst), .wr_en(wr_en[2]), .wr_data(wr_data[2][6:0]), .ovf_clr(ovf_clr),
    .tx(tx[2]), .full(full[2]), .empty(empty[2]), .level(level[2]),
    .overflow(overflow[2]), .busy(busy[2]));

  uart_tx_fifo #(.DATA_BITS(8), .DEPTH(16), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(2)) u_8n2 (
    .clk(clk), .rst(rst), .wr_en(wr_en[3]), .wr_data(wr_data[3]), .ovf_clr(ovf_clr),
    .tx(tx[3]), .full(full[3]), .empty(empty[3]), .level(level[3]),
    .overflow(overflow[3]), .busy(busy[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks tx over a run of bit periods, one sample per clock. The caller is
  // at the negedge of the first expected start-bit cycle. On return the
  // bench is at the negedge just after the last bit.
  task automatic chk_frame(input int d, input string tag, input string bits);
    logic exp_b;
    for (int i = 0; i < bits.len(); i++) begin
      exp_b = (bits.getc(i) == 8'h31);
      for (int c = 0; c < CPB; c++) begin
        chk($sformatf("%s_b%0d_c%0d", tag, i, c), 32'(tx[d]), 32'(exp_b));
        @(negedge clk);
      end
    end
    $display("frame %s on dut%0d: %0d bits checked", tag, d, bits.len());
  endtask

  function automatic string frame8n1(input logic [7:0] b);
    string s;
    s = "0";
    for (int i = 0; i < 8; i++) begin
      s = b[i] ? {s, "1"} : {s, "0"};
    end
    return {s, "1"};
  endfunction

  initial begin
    rst     = 1'b1;
    ovf_clr = 1'b0;
    for (int d = 0; d < 4; d++) begin
      wr_en[d]   = 1'b0;
      wr_data[d] = 8'h00;
    end
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_tx",    32'(tx[0]),       32'd1);
    chk("rst_level", 32'(level[0]),    32'd0);
    chk("rst_empty", 32'(empty[0]),    32'd1);
    chk("rst_full",  32'(full[0]),     32'd0);
    chk("rst_ovf",   32'(overflow[0]), 32'd0);
    chk("rst_busy",  32'(busy[0]),     32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single byte 0x74, 8N1: push at N, pop at N+1, start bit at N+2
    wr_en[0] = 1'b1; wr_data[0] = 8'h74;
    @(negedge clk);
    wr_en[0] = 1'b0;
    chk("one_n1_tx",    32'(tx[0]),    32'd1);
    chk("one_n1_level", 32'(level[0]), 32'd1);
    chk("one_n1_empty", 32'(empty[0]), 32'd0);
    chk("one_n1_busy",  32'(busy[0]),  32'd1);
    @(negedge clk);
    chk("one_pop_level", 32'(level[0]), 32'd0);
    chk("one_pop_empty", 32'(empty[0]), 32'd1);
    chk_frame(0, "f74", "0001011101");
    chk("one_end_busy",  32'(busy[0]),  32'd0);
    chk("one_end_level", 32'(level[0]), 32'd0);
    chk("one_end_tx",    32'(tx[0]),    32'd1);

    // Back-to-back 0x68, 0x69: no gap between frames
    wr_en[0] = 1'b1; wr_data[0] = 8'h68;
    @(negedge clk);
    wr_data[0] = 8'h69;
    chk("b2b_level1", 32'(level[0]), 32'd1);
    @(negedge clk);
    wr_en[0] = 1'b0;
    chk("b2b_level2", 32'(level[0]), 32'd1);   // push and pop in the same cycle
    chk_frame(0, "b2b", "00001011010100101101");
    chk("b2b_end_busy", 32'(busy[0]), 32'd0);

    // Overflow: a prime byte keeps the FSM busy, then 16 pushes fill the FIFO
    wr_en[0] = 1'b1; wr_data[0] = 8'h01;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      wr_data[0] = 8'(8'h10 + i);
    end
    @(negedge clk);
    chk("ovf_level16", 32'(level[0]),    32'd16);
    chk("ovf_full",    32'(full[0]),     32'd1);
    chk("ovf_pre",     32'(overflow[0]), 32'd0);
    wr_data[0] = 8'hEE;                         // 17th push, dropped
    @(negedge clk);
    chk("ovf_set",     32'(overflow[0]), 32'd1);
    chk("ovf_level",   32'(level[0]),    32'd16);
    ovf_clr = 1'b1; wr_data[0] = 8'hDD;         // drop and clear together
    @(negedge clk);
    chk("ovf_set_wins", 32'(overflow[0]), 32'd1);
    wr_en[0] = 1'b0;
    @(negedge clk);
    chk("ovf_cleared", 32'(overflow[0]), 32'd0);
    ovf_clr = 1'b0;
    repeat (22) @(negedge clk);                 // rest of the prime frame
    chk("ovf_pop_level", 32'(level[0]), 32'd15);
    chk("ovf_pop_full",  32'(full[0]),  32'd0);
    for (int i = 0; i < 16; i++) begin
      chk_frame(0, $sformatf("ovf%0d", i), frame8n1(8'(8'h10 + i)));
    end
    chk("ovf_end_busy",  32'(busy[0]),  32'd0);
    chk("ovf_end_level", 32'(level[0]), 32'd0);

    // 7E1, 0x07: three ones, so the even parity bit is 1
    wr_en[1] = 1'b1; wr_data[1] = 8'h07;
    @(negedge clk);
    wr_en[1] = 1'b0;
    @(negedge clk);
    chk_frame(1, "f7e1", "0111000011");
    chk("f7e1_busy", 32'(busy[1]), 32'd0);

    // 7O1, 0x07: the odd parity bit is 0
    wr_en[2] = 1'b1; wr_data[2] = 8'h07;
    @(negedge clk);
    wr_en[2] = 1'b0;
    @(negedge clk);
    chk_frame(2, "f7o1", "0111000001");
    chk("f7o1_busy", 32'(busy[2]), 32'd0);

    // 8N2, 0x55 then 0xAA: 8 high cycles between the last data bit and the next start
    wr_en[3] = 1'b1; wr_data[3] = 8'h55;
    @(negedge clk);
    wr_data[3] = 8'hAA;
    @(negedge clk);
    wr_en[3] = 1'b0;
    chk_frame(3, "f8n2", "0101010101100101010111");
    chk("f8n2_busy", 32'(busy[3]), 32'd0);

    // Reset during data bit 3, with 3 bytes still queued
    wr_en[0] = 1'b1; wr_data[0] = 8'h00;
    @(negedge clk); wr_data[0] = 8'h11;
    @(negedge clk); wr_data[0] = 8'h22;
    @(negedge clk); wr_data[0] = 8'h33;
    @(negedge clk); wr_en[0] = 1'b0;
    repeat (15) @(negedge clk);
    chk("mid_tx_bit3", 32'(tx[0]),    32'd0);
    chk("mid_level",   32'(level[0]), 32'd3);
    chk("mid_busy",    32'(busy[0]),  32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_tx",    32'(tx[0]),       32'd1);
    chk("mid_rst_level", 32'(level[0]),    32'd0);
    chk("mid_rst_empty", 32'(empty[0]),    32'd1);
    chk("mid_rst_busy",  32'(busy[0]),     32'd0);
    chk("mid_rst_ovf",   32'(overflow[0]), 32'd0);
    chk("mid_rst_full",  32'(full[0]),     32'd0);
    rst = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst_idle_%0d", i), 32'(tx[0]), 32'd1);
    end
    chk("post_rst_busy", 32'(busy[0]), 32'd0);
    $display("reset mid-frame sequence checked");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
